wb_arbiter: RTL

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter.sv | 94 +++++++++
 1 files changed

// File: rtl/wb_arbiter.sv
// Two-requester register-file writeback arbiter: ALU (A) and load (B) share one write port.
// Round-robin or fixed-priority grant, one-cycle registered write, saturating contention counter.
module wb_arbiter #(
    parameter int RR_EN = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a_valid,
    input  logic [4:0]       a_rd,
    input  logic [31:0]      a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [4:0]       b_rd,
    input  logic [31:0]      b_data,
    output logic             b_ready,
    output logic             reg_write,
    output logic [4:0]       rd,
    output logic [31:0]      write_data,
    output logic [CNT_W-1:0] conflict_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             a_grant_s;
    logic             b_grant_s;
    logic             last_b_r;
    logic             reg_write_r;
    logic [4:0]       rd_r;
    logic [31:0]      write_data_r;
    logic [CNT_W-1:0] conflict_cnt_r;

    // Grant selection: at most one requester, none while in reset.
    always_comb begin
        a_grant_s = 1'b0;
        b_grant_s = 1'b0;
        if (reset) begin
            a_grant_s = 1'b0;
            b_grant_s = 1'b0;
        end else if (a_valid && b_valid) begin
            // On a tie, round-robin favours whoever was not served last.
            if ((RR_EN != 0) && !last_b_r) begin
                b_grant_s = 1'b1;
            end else begin
                a_grant_s = 1'b1;
            end
        end else if (a_valid) begin
            a_grant_s = 1'b1;
        end else if (b_valid) begin
            b_grant_s = 1'b1;
        end else begin
            a_grant_s = 1'b0;
            b_grant_s = 1'b0;
        end
    end

    // Write-port register, priority pointer and contention counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            reg_write_r    <= 1'b0;
            rd_r           <= 5'd0;
            write_data_r   <= 32'd0;
            conflict_cnt_r <= {CNT_W{1'b0}};
            last_b_r       <= 1'b1;
        end else begin
            if (a_grant_s) begin
                // x0 is hardwired: handshake completes but no write strobe.
                reg_write_r  <= (a_rd != 5'd0);
                rd_r         <= a_rd;
                write_data_r <= a_data;
                last_b_r     <= 1'b0;
            end else if (b_grant_s) begin
                reg_write_r  <= (b_rd != 5'd0);
                rd_r         <= b_rd;
                write_data_r <= b_data;
                last_b_r     <= 1'b1;
            end else begin
                reg_write_r  <= 1'b0;
            end
            if (a_valid && b_valid && (conflict_cnt_r != CNT_MAX)) begin
                conflict_cnt_r <= conflict_cnt_r + CNT_ONE;
            end
        end
    end

    assign a_ready      = a_grant_s;
    assign b_ready      = b_grant_s;
    assign reg_write    = reg_write_r;
    assign rd           = rd_r;
    assign write_data   = write_data_r;
    assign conflict_cnt = conflict_cnt_r;

endmodule
